regfile_write_sched: RTL

- Single-write-port scheduler in front of the 16x16 register file.
- Shares the one write port between the pipeline write-back stage and the interrupt/CALL PC-save engine.
- The PC-save engine stores a 32-bit PC into two private registers (low half, high half) as two 16-bit beats.
- Write-back has priority. A starvation counter guarantees PC-save progress by stalling write-back when needed.

---
 rtl/regfile_write_sched.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regfile_write_sched.sv
// regfile_write_sched: single write port arbiter for the 16x16 register file.
// Write-back has priority; PC-save beats are forced through after STARVE_MAX yields.
module regfile_write_sched #(
  parameter logic [3:0]  LO_ADDR    = 4'd9,
  parameter logic [3:0]  HI_ADDR    = 4'd10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        wb_stall,
  input  logic        ps_req,
  input  logic [31:0] ps_pc,
  output logic        ps_busy,
  output logic        ps_ack,
  output logic        rf_we,
  output logic [3:0]  rf_addr,
  output logic [15:0] rf_data
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] pc_buf;
  logic [31:0] pc_buf_n;
  logic        rf_we_n;
  logic [3:0]  rf_addr_n;
  logic [15:0] rf_data_n;
  logic        busy_n;
  logic        ack_n;
  logic        yield;

  // A pending beat yields only while the starvation budget lasts.
  assign yield = wb_we && (cnt < SMAX);

  // Next-state, grant selection and stall decision.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pc_buf_n  = pc_buf;
    rf_we_n   = 1'b0;
    rf_addr_n = rf_addr;
    rf_data_n = rf_data;
    busy_n    = ps_busy;
    ack_n     = 1'b0;
    wb_stall  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb_we) begin
          rf_we_n   = 1'b1;
          rf_addr_n = wb_addr;
          rf_data_n = wb_data;
        end
        if (ps_req && !ps_ack) begin
          pc_buf_n = ps_pc;
          cnt_n    = 4'd0;
          busy_n   = 1'b1;
          state_n  = LO;
        end
      end
      LO, HI: begin
        if (yield) begin
          rf_we_n   = 1'b1;
          rf_addr_n = wb_addr;
          rf_data_n = wb_data;
          cnt_n     = cnt + 4'd1;
        end else begin
          rf_we_n  = 1'b1;
          cnt_n    = 4'd0;
          wb_stall = wb_we;
          if (state == LO) begin
            rf_addr_n = LO_ADDR;
            rf_data_n = pc_buf[15:0];
            state_n   = HI;
          end else begin
            rf_addr_n = HI_ADDR;
            rf_data_n = pc_buf[31:16];
            state_n   = IDLE;
            busy_n    = 1'b0;
            ack_n     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) wb_stall = 1'b0;
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pc_buf  <= 32'd0;
      rf_we   <= 1'b0;
      rf_addr <= 4'd0;
      rf_data <= 16'd0;
      ps_busy <= 1'b0;
      ps_ack  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pc_buf  <= pc_buf_n;
      rf_we   <= rf_we_n;
      rf_addr <= rf_addr_n;
      rf_data <= rf_data_n;
      ps_busy <= busy_n;
      ps_ack  <= ack_n;
    end
  end

endmodule
